// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word types for the front end.
//   WORD_BITS      width of an instruction word and of a byte address
//   word_t         one instruction word or address
//   fetch_entry_t  one fetch queue slot, holding the fetch PC and the word read at it
//   PC_STEP        PC increment between sequential instruction words
//   align_word()   clears the two byte-offset bits of an address
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam int unsigned PC_STEP = 4;

  function automatic word_t align_word(input word_t a);
    return {a[WORD_BITS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetched entries. It supports push, pop,
// flush and an occupancy count.
//   CLK, nRST  clock and asynchronous active-low reset
//   i_push     write i_data at the tail. It is ignored when the buffer is full.
//   i_pop      drop the head entry. It is ignored when the buffer is empty.
//   i_flush    empty the buffer. It takes priority over push and pop.
//   i_data     entry to write
//   o_head     head entry. It reads as zero when the buffer is empty.
//   o_valid    the head entry is present
//   o_count    occupancy, from 0 to DEPTH
// DEPTH must be a power of two and at least 2.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [63:0]
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  T                       i_data,
  output T                       o_head,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != FULL_CNT);
  assign w_do_pop  = i_pop && (r_count != '0);

  // The pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
  // Full and empty are distinguished by r_count alone.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset. A slot is only visible while r_count says it is
  // occupied, so its reset value does not matter.
  always_ff @(posedge CLK) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: pipeline front end that sits directly upstream of the instruction cache.
// It owns the PC and issues one-word reads to the cache. Each returned word is queued
// together with its PC, and the scheduler pops the queue with a valid/ready handshake.
//   CLK, nRST                   clock and asynchronous active-low reset
//   imemREN, imemaddr           cache read request. The address is held until ihit.
//   ihit, imemload              cache hit and the returned word
//   redirect_valid, redirect_pc new PC; this also flushes the queue and clears halt
//   halt                        sticky stop of fetching
//   inst_valid, inst_ready      queue head handshake
//   inst, inst_pc               head word and its PC. Both read 0 when the queue is empty.
//   fq_count                    queue occupancy
// WORD_W must equal WORD_BITS, because queue entries use the shared fetch_entry_t.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter int                WORD_W   = WORD_BITS,
  parameter logic [WORD_W-1:0] RESET_PC = '0,
  parameter int                FQ_DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      nRST,
  output logic                      imemREN,
  output logic [WORD_W-1:0]         imemaddr,
  input  logic                      ihit,
  input  logic [WORD_W-1:0]         imemload,
  input  logic                      redirect_valid,
  input  logic [WORD_W-1:0]         redirect_pc,
  input  logic                      halt,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [WORD_W-1:0]         inst,
  output logic [WORD_W-1:0]         inst_pc,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FQ_DEPTH);

  logic [WORD_W-1:0] r_pc;
  logic              r_halted;
  logic              w_push;
  logic              w_pop;
  fetch_entry_t      w_entry_in;
  fetch_entry_t      w_head;
  logic [CNT_W-1:0]  w_count;

  // The request depends only on registered state and redirect, so there is no path
  // from inst_ready. Gating with nRST keeps the cache quiet while reset is held.
  assign imemREN  = nRST && !r_halted && !redirect_valid && (w_count < FULL_CNT);
  assign imemaddr = {r_pc[WORD_W-1:2], 2'b00};

  // A hit counts only while a request is out. imemREN is already low during a
  // redirect, so a hit in a redirect cycle is dropped.
  assign w_push = imemREN && ihit;
  assign w_pop  = inst_valid && inst_ready && !redirect_valid;

  assign w_entry_in = '{pc: imemaddr, instr: imemload};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_pc     <= {redirect_pc[WORD_W-1:2], 2'b00};
      r_halted <= 1'b0;
    end else begin
      // The PC advances only on a hit, so a miss holds imemaddr until the fill arrives.
      if (w_push) r_pc <= r_pc + WORD_W'(PC_STEP);
      if (halt)   r_halted <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_entry_in),
    .o_head  (w_head),
    .o_valid (inst_valid),
    .o_count (w_count)
  );

  assign inst     = w_head.instr;
  assign inst_pc  = w_head.pc;
  assign fq_count = w_count;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  fq_count;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: the PC, the halted flag and a queue of {pc, word} entries.
  logic [31:0] m_pc;
  logic        m_halted;
  logic [63:0] m_q[$];

  fetch_stage #(.WORD_W(32), .RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .fq_count(fq_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic m_ren();
    return !m_halted && !redirect_valid && (m_q.size() < 4);
  endfunction

  // Expected outputs, packed as {ren, addr, valid, inst, inst_pc, count}.
  function automatic logic [100:0] m_vec();
    logic [63:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 64'h0;
    return {m_ren(), m_pc, (m_q.size() != 0), h[31:0], h[63:32], 3'(m_q.size())};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    m_halted = 1'b0;
    m_q.delete();
  endtask

  task automatic drive(input logic ih, input logic [31:0] ld, input logic rdy,
                       input logic rv, input logic [31:0] rpc, input logic hl);
    ihit = ih; imemload = ld; inst_ready = rdy;
    redirect_valid = rv; redirect_pc = rpc; halt = hl;
  endtask

  // Advances the model by one clock using the inputs currently driven, then
  // steps the DUT through the rising edge and returns at the falling edge.
  task automatic tick();
    logic push, pop;
    push = m_ren() && ihit && nRST;
    pop  = (m_q.size() != 0) && inst_ready;
    if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_halted = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({m_pc, imemload});
        m_pc = m_pc + 32'd4;
      end
      if (halt) m_halted = 1'b1;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_redirect(input logic [31:0] a);
    drive(1'b0, 32'h0, 1'b0, 1'b1, a, 1'b0);
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge CLK); #1;
    n_total++; if (imemREN !== 1'b0) begin n_bad++; $display("FAIL reset_ren: got %0b want 0", imemREN); end
    n_total++; if (imemaddr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", imemaddr); end
    n_total++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", inst_valid); end
    n_total++; if (inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", inst); end
    n_total++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    n_total++; if (fq_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fq_count); end
    model_reset();
    nRST = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] prev;
    prev = 32'h0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, $urandom, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      n_total++; if (imemaddr !== 32'(4*i)) begin n_bad++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imemaddr, 32'(4*i)); end
      n_total++; if (inst_pc !== ((i > 0) ? 32'(4*(i-1)) : 32'h0)) begin n_bad++; $display("FAIL seq_inst_pc[%0d]: got %h", i, inst_pc); end
      n_total++; if (fq_count !== ((i > 0) ? 3'd1 : 3'd0)) begin n_bad++; $display("FAIL seq_count[%0d]: got %0d", i, fq_count); end
      if (i > 0) begin
        n_total++; if (inst !== prev) begin n_bad++; $display("FAIL seq_inst[%0d]: got %h want %h", i, inst, prev); end
      end
      prev = imemload;
      tick();
    end
  endtask

  task automatic test_miss();
    logic [31:0] w;
    do_redirect(32'h40);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      n_total++; if ({imemREN, imemaddr, fq_count} !== {1'b1, 32'h40, 3'd0}) begin n_bad++; $display("FAIL miss_hold[%0d]: got ren=%0b addr=%h cnt=%0d want 1 00000040 0", i, imemREN, imemaddr, fq_count); end
      tick();
    end
    w = $urandom;
    drive(1'b1, w, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    ihit = 1'b0;
    #1;
    n_total++; if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h40, w}) begin n_bad++; $display("FAIL miss_fill: got v=%0b pc=%h inst=%h want 1 00000040 %h", inst_valid, inst_pc, inst, w); end
    n_total++; if (imemaddr !== 32'h44) begin n_bad++; $display("FAIL miss_next_addr: got %h want 00000044", imemaddr); end
  endtask

  task automatic test_full();
    do_redirect(32'h100);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
    end
    #1;
    n_total++; if ({fq_count, imemREN, imemaddr} !== {3'd4, 1'b0, 32'h110}) begin n_bad++; $display("FAIL full_state: got cnt=%0d ren=%0b addr=%h want 4 0 00000110", fq_count, imemREN, imemaddr); end
    n_total++; if (inst_pc !== 32'h100) begin n_bad++; $display("FAIL full_head_pc: got %h want 00000100", inst_pc); end
    inst_ready = 1'b1;
    #1;
    n_total++; if (imemREN !== 1'b0) begin n_bad++; $display("FAIL full_pop_ren: got %0b want 0", imemREN); end
    tick();
    inst_ready = 1'b0;
    #1;
    n_total++; if ({fq_count, imemREN, imemaddr, inst_pc} !== {3'd3, 1'b1, 32'h110, 32'h104}) begin n_bad++; $display("FAIL full_after_pop: got cnt=%0d ren=%0b addr=%h pc=%h", fq_count, imemREN, imemaddr, inst_pc); end
    tick();
    #1;
    n_total++; if (fq_count !== 3'd4) begin n_bad++; $display("FAIL full_refill: got %0d want 4", fq_count); end
  endtask

  task automatic test_redirect();
    logic [31:0] w;
    do_redirect(32'h200);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h1003, 1'b0);
    #1;
    n_total++; if (imemREN !== 1'b0) begin n_bad++; $display("FAIL redir_ren: got %0b want 0", imemREN); end
    tick();
    w = $urandom & 32'hFFFF_FFFE;
    drive(1'b1, w, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    n_total++; if ({fq_count, imemaddr, inst_valid} !== {3'd0, 32'h1000, 1'b0}) begin n_bad++; $display("FAIL redir_flush: got cnt=%0d addr=%h v=%0b want 0 00001000 0", fq_count, imemaddr, inst_valid); end
    tick();
    #1;
    n_total++; if ({inst_pc, inst} !== {32'h1000, w}) begin n_bad++; $display("FAIL redir_first: got pc=%h inst=%h want 00001000 %h", inst_pc, inst, w); end
  endtask

  task automatic test_halt();
    logic [31:0] w;
    do_redirect(32'h20);
    w = $urandom;
    drive(1'b1, w, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    n_total++; if (imemREN !== 1'b1) begin n_bad++; $display("FAIL halt_ren_same: got %0b want 1", imemREN); end
    tick();
    halt = 1'b0;
    #1;
    n_total++; if ({fq_count, inst_pc, inst, imemREN} !== {3'd1, 32'h20, w, 1'b0}) begin n_bad++; $display("FAIL halt_enq: got cnt=%0d pc=%h inst=%h ren=%0b", fq_count, inst_pc, inst, imemREN); end
    inst_ready = 1'b1;
    tick();
    tick();
    #1;
    n_total++; if ({fq_count, imemREN, imemaddr} !== {3'd0, 1'b0, 32'h24}) begin n_bad++; $display("FAIL halt_drain: got cnt=%0d ren=%0b addr=%h want 0 0 00000024", fq_count, imemREN, imemaddr); end
    do_redirect(32'h80);
    #1;
    n_total++; if ({imemREN, imemaddr} !== {1'b1, 32'h80}) begin n_bad++; $display("FAIL halt_resume: got ren=%0b addr=%h want 1 00000080", imemREN, imemaddr); end
  endtask

  task automatic test_wrap_and_reset();
    do_redirect(32'hFFFF_FFFC);
    drive(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    n_total++; if (imemaddr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pre: got %h want fffffffc", imemaddr); end
    tick();
    ihit = 1'b0;
    #1;
    n_total++; if ({imemaddr, fq_count} !== {32'h0, 3'd1}) begin n_bad++; $display("FAIL wrap_post: got addr=%h cnt=%0d want 00000000 1", imemaddr, fq_count); end
    tick();
    #2 nRST = 1'b0;
    #1;
    n_total++; if ({imemREN, fq_count, imemaddr, inst_valid} !== {1'b0, 3'd0, 32'h0, 1'b0}) begin n_bad++; $display("FAIL midmiss_reset: got ren=%0b cnt=%0d addr=%h v=%0b", imemREN, fq_count, imemaddr, inst_valid); end
    model_reset();
    @(negedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0,
            $urandom, ($urandom % 32) == 0);
      #1;
      n_total++;
      if ({imemREN, imemaddr, inst_valid, inst, inst_pc, fq_count} !== m_vec()) begin
        n_bad++;
        $display("FAIL random[%0d]: got ren=%0b addr=%h v=%0b inst=%h pc=%h cnt=%0d want %h",
                 i, imemREN, imemaddr, inst_valid, inst, inst_pc, fq_count, m_vec());
      end
      tick();
    end
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    test_reset();
    test_sequential();
    test_miss();
    test_full();
    test_redirect();
    test_halt();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
